// File: rtl/imem_align.sv
// rtl/imem_align.sv - instruction memory alignment buffer with two-word window and sequential prefetch
// Returns a 64-bit big-endian window at any halfword offset, spanning lo/hi buffered words.
module imem_align (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] fetch_addr,
    input  logic        fetch_addr_valid,
    output logic [63:0] fetch_data,
    output logic        fetch_data_valid,
    output logic [63:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, FILL_LO, FILL_HI} state_t;

    state_t      state_q;
    logic [63:0] lo_word_q, hi_word_q, fetch_data_q;
    logic [60:0] lo_tag_q, req_tag_q, redir_tag_q;
    logic        lo_valid_q, hi_valid_q, redirect_q, mem_req_q, fetch_data_valid_q;

    logic [60:0] tag, lo_next_tag, new_tag;
    logic [1:0]  off;
    logic        tag_is_lo, tag_is_hi, lo_hit, hi_hit, promote, covered, miss, ack_fire;
    logic        start_lo, start_hi;
    logic [63:0] lo_window, window;
    logic        unused_addr_bit;

    assign tag             = fetch_addr[63:3];
    assign off             = fetch_addr[2:1];
    assign unused_addr_bit = fetch_addr[0];
    assign lo_next_tag     = lo_tag_q + 61'd1;

    assign tag_is_lo = fetch_addr_valid && lo_valid_q && (tag == lo_tag_q);
    assign tag_is_hi = fetch_addr_valid && hi_valid_q && (tag == lo_next_tag);
    assign lo_hit    = tag_is_lo && ((off == 2'd0) || hi_valid_q);
    assign hi_hit    = tag_is_hi && (off == 2'd0);
    assign promote   = tag_is_hi;

    // Addresses already being fetched (or whose second half is about to be
    // prefetched) wait instead of counting as a fresh miss every cycle.
    assign covered = (state_q == FILL_LO && !redirect_q && req_tag_q == tag)
                  || (redirect_q && redir_tag_q == tag)
                  || (tag_is_lo && !hi_valid_q)
                  || (state_q == FILL_HI && !redirect_q && lo_valid_q && req_tag_q == tag);
    assign miss     = fetch_addr_valid && !lo_hit && !promote && !covered;
    assign ack_fire = mem_ack && (state_q != IDLE);

    always_comb begin
        lo_window = lo_word_q;
        case (off)
            2'd0: lo_window = lo_word_q;
            2'd1: lo_window = {lo_word_q[47:0], hi_word_q[63:48]};
            2'd2: lo_window = {lo_word_q[31:0], hi_word_q[63:32]};
            2'd3: lo_window = {lo_word_q[15:0], hi_word_q[63:16]};
            default: lo_window = lo_word_q;
        endcase
        window = hi_hit ? hi_word_q : lo_window;
    end

    // Miss beats prefetch; a redirected request reissues on the discarded ack.
    always_comb begin
        start_lo = 1'b0;
        start_hi = 1'b0;
        new_tag  = tag;
        if (miss && (state_q == IDLE || ack_fire)) begin
            start_lo = 1'b1;
        end else if (!miss && ack_fire && redirect_q) begin
            start_lo = 1'b1;
            new_tag  = redir_tag_q;
        end else if (!miss && state_q == IDLE && lo_valid_q && !hi_valid_q) begin
            start_hi = 1'b1;
            new_tag  = lo_next_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            lo_word_q          <= '0;
            hi_word_q          <= '0;
            lo_tag_q           <= '0;
            req_tag_q          <= '0;
            redir_tag_q        <= '0;
            lo_valid_q         <= 1'b0;
            hi_valid_q         <= 1'b0;
            redirect_q         <= 1'b0;
            mem_req_q          <= 1'b0;
            fetch_data_q       <= '0;
            fetch_data_valid_q <= 1'b0;
        end else begin
            if (ack_fire && !redirect_q && !miss) begin
                if (state_q == FILL_LO) begin
                    lo_word_q  <= mem_rdata;
                    lo_tag_q   <= req_tag_q;
                    lo_valid_q <= 1'b1;
                end else if (lo_valid_q && (lo_tag_q == req_tag_q - 61'd1)) begin
                    hi_word_q  <= mem_rdata;
                    hi_valid_q <= 1'b1;
                end
            end

            if (promote) begin
                lo_word_q  <= hi_word_q;
                lo_tag_q   <= lo_next_tag;
                hi_valid_q <= 1'b0;
            end

            if (miss) begin
                lo_valid_q <= 1'b0;
                hi_valid_q <= 1'b0;
            end

            if (start_lo) begin
                redirect_q <= 1'b0;
            end else if (miss) begin
                redirect_q  <= 1'b1;
                redir_tag_q <= tag;
            end

            if (start_lo || start_hi) begin
                state_q   <= start_lo ? FILL_LO : FILL_HI;
                mem_req_q <= 1'b1;
                req_tag_q <= new_tag;
            end else if (ack_fire) begin
                state_q   <= IDLE;
                mem_req_q <= 1'b0;
            end

            fetch_data_valid_q <= lo_hit || hi_hit;
            fetch_data_q       <= (lo_hit || hi_hit) ? window : 64'd0;
        end
    end

    assign fetch_data       = fetch_data_q;
    assign fetch_data_valid = fetch_data_valid_q;
    assign mem_req          = mem_req_q;
    assign mem_addr         = {req_tag_q, 3'b000};
endmodule

// File: tb/tb_imem_align.sv
// tb/tb_imem_align.sv - directed self-checking bench for imem_align
module tb_imem_align;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] fetch_addr;
    logic        fetch_addr_valid;
    logic [63:0] fetch_data;
    logic        fetch_data_valid;
    logic [63:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] D0 = 64'h0011_2233_4455_6677;
    localparam logic [63:0] D1 = 64'h8899_AABB_CCDD_EEFF;
    localparam logic [63:0] D2 = 64'h1357_9BDF_2468_ACE0;
    localparam logic [63:0] D3 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D4 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D5 = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [63:0] DX = 64'hDEAD_BEEF_DEAD_BEEF;

    imem_align dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_addr(fetch_addr), .fetch_addr_valid(fetch_addr_valid),
        .fetch_data(fetch_data), .fetch_data_valid(fetch_data_valid),
        .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic        av;
        logic [63:0] exp_data;
        logic        exp_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [63:0] d, input logic v);
        chk({name, ".valid"}, {63'd0, fetch_data_valid}, {63'd0, v});
        chk({name, ".data"}, fetch_data, d);
    endtask

    task automatic chk_mem(input string name, input logic r, input logic [63:0] a);
        chk({name, ".mem_req"}, {63'd0, mem_req}, {63'd0, r});
        if (r) chk({name, ".mem_addr"}, mem_addr, a);
    endtask

    initial begin
        vecs[0] = '{64'h0, 1'b1, D0, 1'b1};
        vecs[1] = '{64'h2, 1'b1, 64'h2233_4455_6677_8899, 1'b1};
        vecs[2] = '{64'h4, 1'b1, 64'h4455_6677_8899_AABB, 1'b1};
        vecs[3] = '{64'h6, 1'b1, 64'h6677_8899_AABB_CCDD, 1'b1};
        vecs[4] = '{64'h7, 1'b1, 64'h6677_8899_AABB_CCDD, 1'b1};
        vecs[5] = '{64'h6, 1'b0, 64'h0, 1'b0};
        vecs[6] = '{64'h0, 1'b1, D0, 1'b1};

        rst_n = 1'b0;
        fetch_addr = 64'h0;
        fetch_addr_valid = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = 64'h0;
        tick(); tick();
        chk_out("reset", 64'h0, 1'b0);
        chk("reset.mem_req", {63'd0, mem_req}, 64'd0);
        chk("reset.mem_addr", mem_addr, 64'h0);
        rst_n = 1'b1;

        // Cold start
        tick();
        chk_mem("cold_req", 1'b1, 64'h0);
        mem_ack = 1'b1; mem_rdata = D0;
        tick();
        mem_ack = 1'b0;
        chk_out("cold_fill", 64'h0, 1'b0);
        chk_mem("cold_fill", 1'b0, 64'h0);
        tick();
        chk_out("cold_hit", D0, 1'b1);
        chk_mem("cold_prefetch", 1'b1, 64'h8);
        mem_ack = 1'b1; mem_rdata = D1;
        tick();
        mem_ack = 1'b0;
        chk_mem("hi_fill", 1'b0, 64'h0);

        // Window table over lo=D0, hi=D1
        for (int i = 0; i < 7; i++) begin
            fetch_addr = vecs[i].addr;
            fetch_addr_valid = vecs[i].av;
            tick();
            chk_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid);
            chk_mem($sformatf("vec%0d", i), 1'b0, 64'h0);
        end
        fetch_addr_valid = 1'b1;

        // Sequential crossing
        fetch_addr = 64'h8;
        tick();
        chk_out("cross_hi_hit", D1, 1'b1);
        chk_mem("cross_hi_hit", 1'b0, 64'h0);
        tick();
        chk_out("cross_lo_hit", D1, 1'b1);
        chk_mem("cross_prefetch", 1'b1, 64'h10);

        // Redirect with slow memory
        fetch_addr = 64'h100;
        tick();
        chk_out("redir_miss", 64'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_mem($sformatf("slow%0d", i), 1'b1, 64'h10);
            chk_out($sformatf("slow%0d", i), 64'h0, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = DX;
        tick();
        mem_ack = 1'b0;
        chk_out("redir_drop", 64'h0, 1'b0);
        chk_mem("redir_reissue", 1'b1, 64'h100);
        tick();
        chk_mem("redir_hold", 1'b1, 64'h100);
        chk_out("redir_hold", 64'h0, 1'b0);
        mem_ack = 1'b1; mem_rdata = D2;
        tick();
        mem_ack = 1'b0;
        chk_out("redir_fill", 64'h0, 1'b0);
        tick();
        chk_out("redir_hit", D2, 1'b1);
        chk_mem("redir_prefetch", 1'b1, 64'h108);
        mem_ack = 1'b1; mem_rdata = D3;
        tick();
        mem_ack = 1'b0;
        chk_out("redir_hit2", D2, 1'b1);

        // Promote without hit, then straddle once the next word arrives
        fetch_addr = 64'h10A;
        tick();
        chk_out("promote", 64'h0, 1'b0);
        tick();
        chk_out("promote_wait", 64'h0, 1'b0);
        chk_mem("promote_prefetch", 1'b1, 64'h110);
        mem_ack = 1'b1; mem_rdata = D4;
        tick();
        mem_ack = 1'b0;
        chk_out("promote_fill", 64'h0, 1'b0);
        tick();
        chk_out("promote_straddle", 64'h4567_89AB_CDEF_FEDC, 1'b1);

        // Tag wraparound
        fetch_addr = 64'hFFFF_FFFF_FFFF_FFF8;
        tick();
        chk_out("wrap_miss", 64'h0, 1'b0);
        chk_mem("wrap_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        mem_ack = 1'b1; mem_rdata = D5;
        tick();
        mem_ack = 1'b0;
        tick();
        chk_out("wrap_hit", D5, 1'b1);
        chk_mem("wrap_prefetch", 1'b1, 64'h0);

        // Asynchronous reset while a request is outstanding
        #3;
        rst_n = 1'b0;
        #1;
        chk_mem("async_rst", 1'b0, 64'h0);
        chk_out("async_rst", 64'h0, 1'b0);
        fetch_addr_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = DX;
        tick();
        mem_ack = 1'b0;
        chk_mem("stray_ack", 1'b0, 64'h0);
        chk_out("stray_ack", 64'h0, 1'b0);
        fetch_addr_valid = 1'b1;
        tick();
        chk_out("post_rst_miss", 64'h0, 1'b0);
        chk_mem("post_rst_req", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
